trade_mean_rev: RTL
===================

# trade_mean_rev

Parametrised mean-reversion signal generator with position tracking. It is the successor to the single-cycle mean-reversion comparator in the trading pipeline. It sits between the SMA pre-processing stage and the trade logic unit (TLU). It adds runtime thresholds, a FLAT/LONG/SHORT position state machine, reversion-to-mean exits and a post-exit cooldown. Outputs are registered one-cycle pulses aligned with `data_valid_mean`.

## Interface
- `DATA_W`, default 8: width of prices and SMAs (unsigned).
- `THRESH_W`, default 8: width of the runtime threshold (unsigned, `THRESH_W` ≤ `DATA_W`).
- `COOL_W`, default 4: width of the cooldown sample count.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `data_valid_pre`, input, 1: sample strobe. Inputs are sampled only when it is high.
- `short_sma`, input, `DATA_W`: short moving average.
- `long_sma`, input, `DATA_W`: long moving average.
- `current_data`, input, `DATA_W`: current price.
- `threshold`, input, `THRESH_W`: band half-width around the mean.
- `cooldown_cycles`, input, `COOL_W`: number of valid samples to block entries after an exit.
- `enable`, input, 1: entry permit. Exits are always allowed.
- `buy_signal`, output, 1: one-cycle buy pulse (long entry or short exit).
- `sell_signal`, output, 1: one-cycle sell pulse (short entry or long exit).
- `data_valid_mean`, output, 1: `data_valid_pre` delayed by one cycle.
- `position`, output, 2: current position. 00 = FLAT, 01 = LONG, 10 = SHORT, 11 = COOLDOWN.

## Operation
Arithmetic, all combinational on the sampled inputs:
- `mid = (short_sma + long_sma) >> 1`. The sum is computed at `DATA_W`+1 bits, so it never wraps.
- `upper = min(mid + threshold, 2^DATA_W − 1)`. Saturating.
- `lower = (mid > threshold) ? mid − threshold : 0`.
- `up_trend = short_sma > long_sma`.
- `dn_trend = short_sma < long_sma`.
- When `short_sma == long_sma`, neither trend is true and no entry is possible.

State machine. It advances only on cycles with `data_valid_pre = 1` and holds otherwise.
- FLAT:
  - `enable && up_trend && current_data < lower` → buy pulse, go to LONG.
  - `enable && dn_trend && current_data > upper` → sell pulse, go to SHORT.
  - Otherwise stay in FLAT.
- LONG:
  - `current_data >= mid` → sell pulse (exit), go to COOLDOWN with counter loaded from `cooldown_cycles`.
  - If `cooldown_cycles == 0`, go directly to FLAT instead.
- SHORT:
  - `current_data <= mid` → buy pulse (exit), same cooldown rule as LONG.
- COOLDOWN:
  - Each valid sample decrements the counter.
  - On the valid sample where the counter reaches 0, go to FLAT.
  - No pulses are issued in COOLDOWN. The entry check resumes on the first valid sample after FLAT is reached.
- Entry and exit are never issued on the same sample. Never emit buy and sell together.
- `enable` deasserted mid-position does not force an exit.

## Timing
- Latency: one cycle. Inputs sampled at edge N produce `buy_signal`/`sell_signal`/`position` visible after edge N.
- `data_valid_mean` equals `data_valid_pre` delayed by one cycle.
- Pulses are high for exactly one cycle and only in a cycle where `data_valid_mean = 1`.
- Reset (`rst_n` low, asynchronous, takes effect immediately, including mid-position or mid-cooldown):
  - `buy_signal` = 0, `sell_signal` = 0, `data_valid_mean` = 0.
  - `position` = FLAT, cooldown counter = 0.
- First sample evaluated: the first `data_valid_pre` sampled at a rising edge after `rst_n` deasserts.
- `threshold` and `cooldown_cycles` are sampled with the data. A change takes effect on the next valid sample.

## Configuration
- Macro `TRADE_MEAN_REV_COOLDOWN_EN`.
- Defined: COOLDOWN state and counter are built as described above.
- Undefined:
  - No counter and no COOLDOWN state. Exits go directly to FLAT.
  - `cooldown_cycles` is ignored. `position` never reads 11.

## Test plan
- Long round trip: `threshold` = 5, `short_sma` = 110, `long_sma` = 100 (so mid = 105, lower = 100).
  - `current_data` = 99 → `buy_signal` pulse, `position` = LONG.
  - Then 104 → no pulse.
  - Then 105 → `sell_signal` pulse, `position` = FLAT (with `cooldown_cycles` = 0).
- Short entry: `short_sma` = 100, `long_sma` = 110, `threshold` = 5 (upper = 110).
  - `current_data` = 110 → no pulse.
  - 111 → `sell_signal` pulse, `position` = SHORT.
  - 105 → `buy_signal` pulse.
- Cooldown (macro defined): `cooldown_cycles` = 3, long exit, then three valid entry-qualifying samples.
  - No pulses; `position` = 11 for those samples.
  - FLAT after the 3rd sample.
  - An entry pulse on the 4th sample.
- Saturation and equality, with `DATA_W` = 8:
  - `short_sma` = 255, `long_sma` = 255 → mid = 255, no entry (no trend).
  - `short_sma` = 250, `long_sma` = 252, `threshold` = 10 → upper = 255; `current_data` = 255 → no sell.
- Valid gating and `enable`:
  - Qualifying inputs with `data_valid_pre` = 0 → no pulse, state held.
  - `enable` = 0 in FLAT with a qualifying buy → no pulse.
  - `enable` = 0 while LONG → exit still fires.
- Asynchronous reset mid-LONG: assert `rst_n` = 0 between edges.
  - Outputs go to 0 and `position` to FLAT immediately, without waiting for a clock edge.
  - After release, the first valid sample is evaluated from FLAT.

Source files
------------

// File: rtl/trade_mean_rev.sv
// Mean-reversion signal generator with a FLAT/LONG/SHORT position tracker and registered buy/sell pulses.
// Define TRADE_MEAN_REV_COOLDOWN_EN to build the post-exit COOLDOWN state and its sample counter.
module trade_mean_rev #(
  parameter int DATA_W   = 8,
  parameter int THRESH_W = 8,
  parameter int COOL_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_valid_pre,
  input  logic [DATA_W-1:0]   short_sma,
  input  logic [DATA_W-1:0]   long_sma,
  input  logic [DATA_W-1:0]   current_data,
  input  logic [THRESH_W-1:0] threshold,
  input  logic [COOL_W-1:0]   cooldown_cycles,
  input  logic                enable,
  output logic                buy_signal,
  output logic                sell_signal,
  output logic                data_valid_mean,
  output logic [1:0]          position
);

  typedef enum logic [1:0] {
    FLAT  = 2'b00,
    LONG  = 2'b01,
    SHORT = 2'b10
`ifdef TRADE_MEAN_REV_COOLDOWN_EN
    , COOL = 2'b11
`endif
  } pos_e;

  // floor((a + b) / 2) without needing a DATA_W+1 bit sum
  function automatic logic [DATA_W-1:0] half_sum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a >> 1) + (b >> 1) + {{(DATA_W-1){1'b0}}, a[0] & b[0]};
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] floor_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  logic [DATA_W-1:0] thr_d, mid_d, upper_d, lower_d;
  logic              up_trend_d, dn_trend_d;
  logic              enter_long_d, enter_short_d;

  assign thr_d         = DATA_W'(threshold);
  assign mid_d         = half_sum(short_sma, long_sma);
  assign upper_d       = sat_add(mid_d, thr_d);
  assign lower_d       = floor_sub(mid_d, thr_d);
  assign up_trend_d    = short_sma > long_sma;
  assign dn_trend_d    = short_sma < long_sma;
  assign enter_long_d  = enable && up_trend_d && (current_data < lower_d);
  assign enter_short_d = enable && dn_trend_d && (current_data > upper_d);

  pos_e state_q, exit_state_d;
  logic buy_q, sell_q, dv_q;

`ifdef TRADE_MEAN_REV_COOLDOWN_EN
  logic [COOL_W-1:0] cnt_q;
  assign exit_state_d = (cooldown_cycles != '0) ? COOL : FLAT;
`else
  logic unused_cooldown;
  assign unused_cooldown = ^cooldown_cycles;
  assign exit_state_d    = FLAT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLAT;
      buy_q   <= 1'b0;
      sell_q  <= 1'b0;
      dv_q    <= 1'b0;
`ifdef TRADE_MEAN_REV_COOLDOWN_EN
      cnt_q   <= '0;
`endif
    end else begin
      dv_q   <= data_valid_pre;
      buy_q  <= 1'b0;
      sell_q <= 1'b0;
      if (data_valid_pre) begin
        case (state_q)
          FLAT: begin
            if (enter_long_d) begin
              buy_q   <= 1'b1;
              state_q <= LONG;
            end else if (enter_short_d) begin
              sell_q  <= 1'b1;
              state_q <= SHORT;
            end
          end
          LONG: begin
            if (current_data >= mid_d) begin
              sell_q  <= 1'b1;
              state_q <= exit_state_d;
`ifdef TRADE_MEAN_REV_COOLDOWN_EN
              cnt_q   <= cooldown_cycles;
`endif
            end
          end
          SHORT: begin
            if (current_data <= mid_d) begin
              buy_q   <= 1'b1;
              state_q <= exit_state_d;
`ifdef TRADE_MEAN_REV_COOLDOWN_EN
              cnt_q   <= cooldown_cycles;
`endif
            end
          end
`ifdef TRADE_MEAN_REV_COOLDOWN_EN
          COOL: begin
            cnt_q <= (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            if (cnt_q <= COOL_W'(1)) state_q <= FLAT;
          end
`endif
          default: state_q <= FLAT;
        endcase
      end
    end
  end

  assign buy_signal      = buy_q;
  assign sell_signal     = sell_q;
  assign data_valid_mean = dv_q;
  assign position        = state_q;

endmodule
